regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
Shares the register file's single read port (A, registered 1-cycle read) and single write port between two requesters: the core pipeline and a debug/host loader. Each cycle it grants one operation, either a read or a write. It steers the granted address and data to the register file and routes returned read data back to the owner with a valid strobe. It supports round-robin or core-priority arbitration; the core-priority mode has a starvation guard for the debug port.

Parameters:
PRIO_MODE, 0, 0 = round-robin; 1 = core fixed priority with debug starvation guard
MAX_WAIT, 4, denied-cycle count at which debug is forced a grant (PRIO_MODE=1 only); range 1..15
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
core_req  in  1  core operation request
core_we  in  1  1 = write, 0 = read
core_addr  in  AW  register index
core_wdata  in  DW  write data
core_gnt  out  1  core operation accepted this cycle (combinational)
core_rvalid  out  1  core read data valid (registered)
core_rdata  out  DW  core read data
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug request, same meaning as the core signals
dbg_gnt  out  1  debug operation accepted
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DW  debug read data
rf_addA  out  AW  register file read address
rf_addD  out  AW  register file write address
rf_WB_out  out  DW  register file write data
rf_RegWrite  out  1  register file write enable
rf_dataA  in  DW  register file read data, valid 1 cycle after address
dbg_starved  out  1  high in cycles where debug wins only because of the guard

Behaviour:
- Reset (rst=1, async): last_gnt=DEBUG (so the core wins the first tie), wait_cnt=0, rvalid tags cleared. While rst is high: core_gnt, dbg_gnt, rf_RegWrite, core_rvalid, dbg_rvalid and dbg_starved are 0; rdata outputs are 0.
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt in the same cycle. The transfer completes on the rising edge where req and gnt are both high. A requester may deassert req before it is granted (withdrawal). At most one grant per cycle.
- Arbitration, PRIO_MODE=0: a single requester is granted immediately. With both requesting, the grant goes to the requester not equal to last_gnt. last_gnt updates on every grant.
- Arbitration, PRIO_MODE=1: the core wins when both request, unless wait_cnt==MAX_WAIT, in which case debug wins and dbg_starved=1.
  - wait_cnt increments, saturating at MAX_WAIT, on each cycle with dbg_req & ~dbg_gnt.
  - wait_cnt clears on a debug grant or when dbg_req=0.
- Steering: rf_addA = rf_addD = the granted requester's addr; rf_WB_out = the granted wdata. rf_RegWrite = gnt & we. With no grant, addresses and data are driven 0 and rf_RegWrite=0.
- Writes take effect at the grant edge. Writes to x0 are forwarded but have no architectural effect; x0 always reads 0.
- Read latency is 1 cycle:
  - The tag registers core_rvalid <= core_gnt & ~core_we and dbg_rvalid <= dbg_gnt & ~dbg_we.
  - Each rdata equals rf_dataA when its rvalid=1, otherwise 0.
  - Only one rvalid can be high per cycle.
- A write granted in cycle N followed by a read of the same register granted in cycle N+1 (either requester) returns the new value in cycle N+2.
- Back-to-back reads: one per cycle. Each read's rvalid follows its grant by exactly 1 cycle.
- Reset mid-operation: if rst asserts while a read is in flight, no rvalid is produced after reset release. A write whose grant edge coincides with rst assertion is not guaranteed.

Test Plan:
1. Core write x5=0xDEADBEEF, next cycle core read x5 -> core_gnt both cycles; core_rvalid=1 with core_rdata=0xDEADBEEF in the following cycle; dbg_rvalid=0 throughout.
2. PRIO_MODE=0, both requesters continuously reading x1 (core) and x2 (dbg) after reset -> grants alternate core, dbg, core, dbg starting with core; rvalid alternates 1 cycle later.
3. PRIO_MODE=1, MAX_WAIT=4, both requesting continuously -> core granted in cycles 0-3; dbg granted with dbg_starved=1 in cycle 4; pattern repeats with period 5.
4. Debug writes 0x1234 to x0, then reads x0 -> dbg_rvalid=1, dbg_rdata=0x00000000.
5. Core read granted, rst asserted in the next cycle -> core_rvalid stays 0; all grants and rf_RegWrite are 0 during reset; after release the first tie goes to core.
6. Idle (no requests) for 10 cycles, then debug withdraws req after 2 denied cycles under PRIO_MODE=1 -> rf_RegWrite=0 while idle, wait_cnt returns to 0, no dbg_gnt issued.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares the register file's single registered read port (A) and single write
// port between the core pipeline and the debug/host loader. One operation,
// either a read or a write, is granted per cycle. The granted address and data
// are steered to the register file. Read data returns one cycle after the
// grant, tagged with a valid strobe for the requester that owns it.
//
// Arbitration modes:
//   PRIO_MODE = 0 : round-robin on contention (alternates against last_gnt)
//   PRIO_MODE = 1 : core wins on contention, except that debug is forced
//                   through once it has been denied MAX_WAIT cycles in a row
//
// Ports:
//   clk, rst                          clock (rising edge), async active-high reset
//   core_req/we/addr/wdata            core operation request
//   core_gnt                          core operation accepted (combinational)
//   core_rvalid, core_rdata           core read return (valid registered)
//   dbg_req/we/addr/wdata             debug operation request
//   dbg_gnt                           debug operation accepted (combinational)
//   dbg_rvalid, dbg_rdata             debug read return (valid registered)
//   rf_addA, rf_addD                  register file read / write address
//   rf_WB_out, rf_RegWrite            register file write data / write enable
//   rf_dataA                          register file read data (1 cycle after address)
//   dbg_starved                       debug won only because of the starvation guard
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4,
    parameter int AW        = 5,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] rf_addA,
    output logic [AW-1:0] rf_addD,
    output logic [DW-1:0] rf_WB_out,
    output logic          rf_RegWrite,
    input  logic [DW-1:0] rf_dataA,
    output logic          dbg_starved
);

    typedef enum logic {
        OWNER_CORE  = 1'b0,
        OWNER_DEBUG = 1'b1
    } owner_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    owner_e     last_gnt_q;
    owner_e     last_gnt_d;
    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;
    logic       core_rvalid_q;
    logic       core_rvalid_d;
    logic       dbg_rvalid_q;
    logic       dbg_rvalid_d;

    logic       core_win_s;
    logic       dbg_win_s;
    logic       guard_s;

    // Grant decision; grants are suppressed while reset is asserted.
    always_comb begin
        core_win_s = 1'b0;
        dbg_win_s  = 1'b0;
        guard_s    = 1'b0;
        if (rst) begin
            core_win_s = 1'b0;
            dbg_win_s  = 1'b0;
        end else if (core_req && dbg_req) begin
            if (PRIO_MODE == 0) begin
                // Tie goes to whoever did not win last time.
                if (last_gnt_q == OWNER_DEBUG) begin
                    core_win_s = 1'b1;
                end else begin
                    dbg_win_s = 1'b1;
                end
            end else begin
                // Core priority, unless debug has waited long enough.
                if (wait_cnt_q == MAX_WAIT_C) begin
                    dbg_win_s = 1'b1;
                    guard_s   = 1'b1;
                end else begin
                    core_win_s = 1'b1;
                end
            end
        end else if (core_req) begin
            core_win_s = 1'b1;
        end else if (dbg_req) begin
            dbg_win_s = 1'b1;
        end else begin
            core_win_s = 1'b0;
            dbg_win_s  = 1'b0;
        end
    end

    assign core_gnt    = core_win_s;
    assign dbg_gnt     = dbg_win_s;
    assign dbg_starved = guard_s;

    // Steer the winner's address/data to the register file; idle drives zeros.
    always_comb begin
        rf_addA     = {AW{1'b0}};
        rf_addD     = {AW{1'b0}};
        rf_WB_out   = {DW{1'b0}};
        rf_RegWrite = 1'b0;
        if (core_win_s) begin
            rf_addA     = core_addr;
            rf_addD     = core_addr;
            rf_WB_out   = core_wdata;
            rf_RegWrite = core_we;
        end else if (dbg_win_s) begin
            rf_addA     = dbg_addr;
            rf_addD     = dbg_addr;
            rf_WB_out   = dbg_wdata;
            rf_RegWrite = dbg_we;
        end else begin
            rf_RegWrite = 1'b0;
        end
    end

    // Next-state for arbitration history, starvation counter and read tags.
    always_comb begin
        last_gnt_d    = last_gnt_q;
        wait_cnt_d    = wait_cnt_q;
        core_rvalid_d = core_win_s & ~core_we;
        dbg_rvalid_d  = dbg_win_s & ~dbg_we;

        if (core_win_s) begin
            last_gnt_d = OWNER_CORE;
        end else if (dbg_win_s) begin
            last_gnt_d = OWNER_DEBUG;
        end else begin
            last_gnt_d = last_gnt_q;
        end

        // Counts consecutive denied debug cycles; any gap or grant restarts it.
        if (!dbg_req || dbg_win_s) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // State registers; reset leaves last_gnt at debug so the core wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q    <= OWNER_DEBUG;
            wait_cnt_q    <= 4'd0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            last_gnt_q    <= last_gnt_d;
            wait_cnt_q    <= wait_cnt_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
        end
    end

    // Read data is only presented to the owner of the returning read.
    assign core_rvalid = core_rvalid_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign core_rdata  = core_rvalid_q ? rf_dataA : {DW{1'b0}};
    assign dbg_rdata   = dbg_rvalid_q ? rf_dataA : {DW{1'b0}};

endmodule

// File: tb/tb_regfile_port_arbiter.sv
`timescale 1ns/1ps
// Bench for regfile_port_arbiter: one round-robin instance (index 0) and one
// core-priority instance (index 1, MAX_WAIT=4), each with its own register
// file stub and its own reference model and read-return scoreboard.
module tb_regfile_port_arbiter;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          core_req [2];
    logic          core_we [2];
    logic [AW-1:0] core_addr [2];
    logic [DW-1:0] core_wdata [2];
    logic          core_gnt [2];
    logic          core_rvalid [2];
    logic [DW-1:0] core_rdata [2];
    logic          dbg_req [2];
    logic          dbg_we [2];
    logic [AW-1:0] dbg_addr [2];
    logic [DW-1:0] dbg_wdata [2];
    logic          dbg_gnt [2];
    logic          dbg_rvalid [2];
    logic [DW-1:0] dbg_rdata [2];
    logic [AW-1:0] rf_addA [2];
    logic [AW-1:0] rf_addD [2];
    logic [DW-1:0] rf_WB_out [2];
    logic          rf_RegWrite [2];
    logic [DW-1:0] rf_dataA [2];
    logic          dbg_starved [2];

    regfile_port_arbiter #(.PRIO_MODE(0), .MAX_WAIT(MAXW), .AW(AW), .DW(DW)) dut_rr (
        .clk(clk), .rst(rst),
        .core_req(core_req[0]), .core_we(core_we[0]), .core_addr(core_addr[0]),
        .core_wdata(core_wdata[0]), .core_gnt(core_gnt[0]), .core_rvalid(core_rvalid[0]),
        .core_rdata(core_rdata[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]),
        .dbg_wdata(dbg_wdata[0]), .dbg_gnt(dbg_gnt[0]), .dbg_rvalid(dbg_rvalid[0]),
        .dbg_rdata(dbg_rdata[0]),
        .rf_addA(rf_addA[0]), .rf_addD(rf_addD[0]), .rf_WB_out(rf_WB_out[0]),
        .rf_RegWrite(rf_RegWrite[0]), .rf_dataA(rf_dataA[0]), .dbg_starved(dbg_starved[0])
    );

    regfile_port_arbiter #(.PRIO_MODE(1), .MAX_WAIT(MAXW), .AW(AW), .DW(DW)) dut_pr (
        .clk(clk), .rst(rst),
        .core_req(core_req[1]), .core_we(core_we[1]), .core_addr(core_addr[1]),
        .core_wdata(core_wdata[1]), .core_gnt(core_gnt[1]), .core_rvalid(core_rvalid[1]),
        .core_rdata(core_rdata[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]),
        .dbg_wdata(dbg_wdata[1]), .dbg_gnt(dbg_gnt[1]), .dbg_rvalid(dbg_rvalid[1]),
        .dbg_rdata(dbg_rdata[1]),
        .rf_addA(rf_addA[1]), .rf_addD(rf_addD[1]), .rf_WB_out(rf_WB_out[1]),
        .rf_RegWrite(rf_RegWrite[1]), .rf_dataA(rf_dataA[1]), .dbg_starved(dbg_starved[1])
    );

    // Register file stubs: write at the edge, registered read, x0 hardwired to 0.
    logic [DW-1:0] rf_mem [2][32];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rf_RegWrite[i] && rf_addD[i] != 5'd0) rf_mem[i][rf_addD[i]] <= rf_WB_out[i];
            rf_dataA[i] <= (rf_addA[i] == 5'd0) ? 32'd0 : rf_mem[i][rf_addA[i]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Requester state (index [inst][0=core,1=dbg]).
    logic          pend [2][2];
    logic          pwe [2][2];
    logic [AW-1:0] paddr [2][2];
    logic [DW-1:0] pwd [2][2];

    // Reference model state.
    logic [DW-1:0] m_mem [2][32];
    bit            m_last_dbg [2];
    int            m_wait [2];

    typedef struct {
        bit            dbg;
        logic [DW-1:0] data;
        int            due;
    } rd_t;
    rd_t q0 [$];
    rd_t q1 [$];

    task automatic check(input string nm, input int i, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got %0h, want %0h", nm, i, cyc, act, exp);
        end
    endtask

    // One cycle: refresh requests, drive, then check grant/steering against the model.
    task automatic step(input int req_pct, input int we_pct, input int wd_pct, input logic rst_v);
        logic gc, gd, st, we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        rd_t e;
        @(negedge clk);
        rst = rst_v;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[i][r]) begin
                    if (int'($urandom_range(99)) < req_pct) begin
                        pend[i][r]  = 1'b1;
                        pwe[i][r]   = int'($urandom_range(99)) < we_pct;
                        paddr[i][r] = AW'($urandom_range(7));
                        pwd[i][r]   = $urandom;
                    end
                end else if (int'($urandom_range(99)) < wd_pct) begin
                    pend[i][r] = 1'b0;
                end
            end
            core_req[i] = pend[i][0]; core_we[i] = pwe[i][0];
            core_addr[i] = paddr[i][0]; core_wdata[i] = pwd[i][0];
            dbg_req[i] = pend[i][1]; dbg_we[i] = pwe[i][1];
            dbg_addr[i] = paddr[i][1]; dbg_wdata[i] = pwd[i][1];
        end
        if (rst_v) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                m_last_dbg[i] = 1'b1;
                m_wait[i] = 0;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            gc = 1'b0; gd = 1'b0; st = 1'b0;
            if (!rst_v) begin
                if (pend[i][0] && pend[i][1]) begin
                    if (i == 0) begin
                        if (m_last_dbg[i]) gc = 1'b1; else gd = 1'b1;
                    end else if (m_wait[i] == MAXW) begin
                        gd = 1'b1; st = 1'b1;
                    end else begin
                        gc = 1'b1;
                    end
                end else if (pend[i][0]) begin
                    gc = 1'b1;
                end else if (pend[i][1]) begin
                    gd = 1'b1;
                end
            end
            we = 1'b0; a = '0; wd = '0;
            if (gc) begin we = pwe[i][0]; a = paddr[i][0]; wd = pwd[i][0]; end
            if (gd) begin we = pwe[i][1]; a = paddr[i][1]; wd = pwd[i][1]; end
            check("grant_steer", i,
                  {core_gnt[i], dbg_gnt[i], dbg_starved[i], rf_RegWrite[i],
                   rf_addA[i], rf_addD[i], rf_WB_out[i]},
                  {gc, gd, st, (gc | gd) & we, a, a, wd});
            if (!rst_v) begin
                if (gc) m_last_dbg[i] = 1'b0;
                if (gd) m_last_dbg[i] = 1'b1;
                if (pend[i][1] && !gd) m_wait[i] = (m_wait[i] < MAXW) ? m_wait[i] + 1 : MAXW;
                else m_wait[i] = 0;
                if ((gc || gd) && !we) begin
                    e.dbg = gd;
                    e.data = (a == 5'd0) ? 32'd0 : m_mem[i][a];
                    e.due = cyc + 1;
                    if (i == 0) q0.push_back(e); else q1.push_back(e);
                end
                if ((gc || gd) && we && a != 5'd0) m_mem[i][a] = wd;
                if (gc) pend[i][0] = 1'b0;
                if (gd) pend[i][1] = 1'b0;
            end
        end
    endtask

    task automatic clear_pend();
        for (int i = 0; i < 2; i++) begin
            pend[i][0] = 1'b0;
            pend[i][1] = 1'b0;
        end
    endtask

    task automatic set_req(input int r, input logic w, input logic [AW-1:0] ad,
                           input logic [DW-1:0] d);
        for (int i = 0; i < 2; i++) begin
            pend[i][r] = 1'b1; pwe[i][r] = w; paddr[i][r] = ad; pwd[i][r] = d;
        end
    endtask

    // Read-return monitor: compares rvalid/rdata against the scoreboard every cycle.
    task automatic mon_one(input int i);
        rd_t e;
        bit has;
        logic ecv, edv;
        logic [DW-1:0] ecd, edd;
        has = 1'b0;
        if (i == 0) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); has = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); has = 1'b1; end
        end
        ecv = has && !e.dbg;
        edv = has && e.dbg;
        ecd = ecv ? e.data : 32'd0;
        edd = edv ? e.data : 32'd0;
        check("read_return", i, {core_rvalid[i], dbg_rvalid[i], core_rdata[i], dbg_rdata[i]},
              {ecv, edv, ecd, edd});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < 2; i++) mon_one(i);
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) begin
                pend[i][r] = 1'b0; pwe[i][r] = 1'b0; paddr[i][r] = '0; pwd[i][r] = '0;
            end
            for (int k = 0; k < 32; k++) m_mem[i][k] = 32'd0;
            m_last_dbg[i] = 1'b1;
            m_wait[i] = 0;
        end
        repeat (3) step(0, 0, 0, 1'b1);

        // Give every register a known value through the core port.
        for (int k = 1; k < 32; k++) begin
            set_req(0, 1'b1, AW'(k), $urandom);
            step(0, 0, 0, 1'b0);
        end

        // Core write then read-back of x5.
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        step(0, 0, 0, 1'b0);
        set_req(0, 1'b0, 5'd5, 32'h0);
        repeat (3) step(0, 0, 0, 1'b0);

        // Debug write to x0 is forwarded but x0 still reads zero.
        set_req(1, 1'b1, 5'd0, 32'h00001234);
        step(0, 0, 0, 1'b0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        repeat (3) step(0, 0, 0, 1'b0);

        // Continuous contention right after reset.
        repeat (2) step(0, 0, 0, 1'b1);
        set_req(0, 1'b0, 5'd1, 32'h0);
        set_req(1, 1'b0, 5'd2, 32'h0);
        repeat (22) step(100, 0, 0, 1'b0);

        // Reset while a core read is in flight; then first tie after release.
        clear_pend();
        repeat (2) step(0, 0, 0, 1'b0);
        set_req(0, 1'b0, 5'd3, 32'h0);
        step(0, 0, 0, 1'b0);
        repeat (2) step(0, 0, 0, 1'b1);
        set_req(0, 1'b0, 5'd4, 32'h0);
        set_req(1, 1'b0, 5'd6, 32'h0);
        repeat (4) step(100, 0, 0, 1'b0);

        // Idle, then debug withdraws after being denied; counter must restart.
        clear_pend();
        repeat (10) step(0, 0, 0, 1'b0);
        set_req(0, 1'b0, 5'd1, 32'h0);
        set_req(1, 1'b0, 5'd2, 32'h0);
        step(0, 0, 0, 1'b0);
        set_req(0, 1'b0, 5'd1, 32'h0);
        step(0, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) pend[i][1] = 1'b0;
        repeat (3) step(0, 0, 0, 1'b0);
        set_req(0, 1'b0, 5'd7, 32'h0);
        set_req(1, 1'b0, 5'd7, 32'h0);
        repeat (10) step(100, 20, 0, 1'b0);

        // Randomised traffic with withdrawals and occasional resets.
        for (int blk = 0; blk < 3; blk++) begin
            repeat (800) step(70, 40, 10, 1'b0);
            step(70, 40, 10, 1'b1);
            step(70, 40, 10, 1'b1);
        end
        repeat (200) step(95, 30, 5, 1'b0);

        clear_pend();
        repeat (4) step(0, 0, 0, 1'b0);
        check("drain", 0, q0.size() + q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
